// File: rtl/ecc_xfer_pkg.sv
// Shared state encoding and word-map constants for the ECC operand transfer master.
package ecc_xfer_pkg;

   localparam int WORD_W       = 32;
   localparam int NUM_WORDS    = 12;
   localparam int SCALAR_WORDS = 13;

   localparam logic [1:0] OP_SEL_REG = 2'b00;
   localparam logic [1:0] OP_SEL_KEY = 2'b01;

   localparam logic [3:0] LAST_WORD    = 4'hB;
   localparam logic [3:0] KEY_MSB_WORD = 4'(SCALAR_WORDS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_WORD,
      ST_WR_COMMIT,
      ST_RD_WAIT,
      ST_RD_CAP,
      ST_RD_WORD,
      ST_DONE
   } state_e;

endpackage

// File: rtl/ecc_xfer_rd_assembler.sv
// Word-indexed shadow register that collects read words; load_i copies the
// completed value (including the word arriving this cycle) to data_o.
module ecc_xfer_rd_assembler
   import ecc_xfer_pkg::*;
(
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          wr_en_i,
   input  logic [3:0]                    word_sel_i,
   input  logic [WORD_W-1:0]             word_i,
   input  logic                          load_i,
   output logic [NUM_WORDS*WORD_W-1:0]   shadow_o,
   output logic [NUM_WORDS*WORD_W-1:0]   data_o
);

   logic [NUM_WORDS-1:0][WORD_W-1:0] shadow_q, shadow_d;
   logic [NUM_WORDS*WORD_W-1:0]      data_q;

   always_comb begin
      shadow_d = shadow_q;
      if (wr_en_i && (word_sel_i <= LAST_WORD)) begin
         shadow_d[word_sel_i] = word_i;
      end
   end

   // NOTE: the shadow is reset too, so a readback compare never sees X before its first fill.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow_q <= '0;
         data_q   <= '0;
      end else begin
         shadow_q <= shadow_d;
         if (load_i) begin
            data_q <= shadow_d;
         end
      end
   end

   assign shadow_o = shadow_q;
   assign data_o   = data_q;

endmodule

// File: rtl/ecc_operand_xfer.sv
// Host-side master serialising 384-bit operands / 385-bit scalar over the ECC unit's
// 32-bit word port. Define ECC_OPERAND_XFER_READBACK_CHECK_EN to verify every write by readback.
module ecc_operand_xfer #(
   parameter int REG_SIZE = 384,
   parameter int WORD_W   = 32,
   parameter int RD_LAT   = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                wr_req_i,
   input  logic                rd_req_i,
   input  logic                sel_i,
   input  logic [7:0]          addr_i,
   input  logic [REG_SIZE:0]   wdata_i,
   output logic [REG_SIZE-1:0] rdata_o,
   output logic                done_o,
   output logic                err_o,
   output logic                mismatch_o,
   output logic                busy_o,
   input  logic                unit_busy_i,
   output logic [7:0]          u_addr_o,
   output logic                u_wr_en_o,
   output logic [1:0]          u_wr_op_sel_o,
   output logic [3:0]          u_wr_word_sel_o,
   output logic                u_rd_reg_o,
   output logic [1:0]          u_rd_op_sel_o,
   output logic [3:0]          u_rd_word_sel_o,
   output logic [WORD_W-1:0]   u_wdata_o,
   input  logic [WORD_W-1:0]   u_rdata_i
);

   import ecc_xfer_pkg::*;

   state_e                           state_q, state_d;
   logic [3:0]                       cnt_q, cnt_d;
   logic                             sel_q, sel_d;
   logic                             is_wr_q, is_wr_d;
   logic                             err_q, err_d;
   logic                             post_q;
   logic [7:0]                       addr_q, addr_d;
   logic [REG_SIZE:0]                wdata_q, wdata_d;
   logic [3:0]                       last_wr_word;
   logic [NUM_WORDS-1:0][WORD_W-1:0] wwords;
   logic                             abort;
   logic                             asm_load;
   logic [REG_SIZE-1:0]              shadow;
`ifdef ECC_OPERAND_XFER_READBACK_CHECK_EN
   logic                             rb_q, rb_d;
`endif

   assign last_wr_word = sel_q ? KEY_MSB_WORD : LAST_WORD;
   assign wwords       = wdata_q[REG_SIZE-1:0];
   // A finished transfer sitting in DONE is not aborted; its pulse is already out.
   assign abort        = unit_busy_i && (state_q != ST_IDLE) && (state_q != ST_DONE);

   // NOTE: every next-state signal gets its hold value first, so no branch can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      is_wr_d = is_wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = 1'b0;
`ifdef ECC_OPERAND_XFER_READBACK_CHECK_EN
      rb_d    = rb_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!unit_busy_i && (wr_req_i || rd_req_i)) begin
               sel_d   = sel_i;
               is_wr_d = wr_req_i;
               addr_d  = sel_i ? 8'h00 : addr_i;
               wdata_d = wdata_i;
               cnt_d   = '0;
`ifdef ECC_OPERAND_XFER_READBACK_CHECK_EN
               rb_d    = 1'b0;
`endif
               if (wr_req_i)   state_d = ST_WR_WORD;
               else if (sel_i) state_d = ST_RD_WORD;
               else            state_d = ST_RD_WAIT;
            end
         end
         ST_WR_WORD: begin
            if (cnt_q == last_wr_word) begin
               cnt_d   = '0;
               state_d = sel_q ? ST_DONE : ST_WR_COMMIT;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_WR_COMMIT: state_d = ST_DONE;
         ST_RD_WAIT: begin
            if (cnt_q == 4'(RD_LAT - 1)) begin
               cnt_d   = '0;
               state_d = ST_RD_CAP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RD_CAP: begin
            cnt_d   = '0;
            state_d = ST_RD_WORD;
         end
         ST_RD_WORD: begin
            if (cnt_q == LAST_WORD) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_DONE: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
`ifdef ECC_OPERAND_XFER_READBACK_CHECK_EN
            if (is_wr_q && !rb_q) begin
               rb_d    = 1'b1;
               state_d = sel_q ? ST_RD_WORD : ST_RD_WAIT;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
      if (abort) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         err_d   = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sel_q   <= 1'b0;
         is_wr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         post_q  <= 1'b0;
`ifdef ECC_OPERAND_XFER_READBACK_CHECK_EN
         rb_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         is_wr_q <= is_wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         post_q  <= (state_q != ST_IDLE);
`ifdef ECC_OPERAND_XFER_READBACK_CHECK_EN
         rb_q    <= rb_d;
`endif
      end
   end

   always_comb begin
      u_wr_en_o       = 1'b0;
      u_wr_op_sel_o   = OP_SEL_REG;
      u_wr_word_sel_o = '0;
      u_wdata_o       = '0;
      u_rd_reg_o      = 1'b0;
      u_rd_op_sel_o   = OP_SEL_REG;
      u_rd_word_sel_o = '0;
      case (state_q)
         ST_WR_WORD: begin
            u_wr_en_o       = 1'b1;
            u_wr_op_sel_o   = sel_q ? OP_SEL_KEY : OP_SEL_REG;
            u_wr_word_sel_o = cnt_q;
            u_wdata_o       = (cnt_q == KEY_MSB_WORD) ? {{(WORD_W-1){1'b0}}, wdata_q[REG_SIZE]}
                                                      : wwords[cnt_q];
         end
         ST_RD_CAP: u_rd_reg_o = 1'b1;
         ST_RD_WORD: begin
            u_rd_op_sel_o   = sel_q ? OP_SEL_KEY : OP_SEL_REG;
            u_rd_word_sel_o = cnt_q;
         end
         default: ;
      endcase
   end

   // The final word is merged straight into the output so rdata_o is valid alongside done_o.
   assign asm_load = (state_q == ST_RD_WORD) && (cnt_q == LAST_WORD) && !is_wr_q && !unit_busy_i;

   ecc_xfer_rd_assembler u_asm (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en_i    (state_q == ST_RD_WORD),
      .word_sel_i (cnt_q),
      .word_i     (u_rdata_i),
      .load_i     (asm_load),
      .shadow_o   (shadow),
      .data_o     (rdata_o)
   );

   assign busy_o   = (state_q != ST_IDLE);
   assign err_o    = err_q;
   assign u_addr_o = (busy_o || post_q) ? addr_q : 8'h00;

`ifdef ECC_OPERAND_XFER_READBACK_CHECK_EN
   // The first DONE of a write only launches the readback; the pulse comes after it.
   assign done_o     = (state_q == ST_DONE) && !(is_wr_q && !rb_q);
   assign mismatch_o = done_o && rb_q && (shadow != wdata_q[REG_SIZE-1:0]);
`else
   logic unused_shadow;
   assign unused_shadow = ^shadow;
   assign done_o        = (state_q == ST_DONE);
   assign mismatch_o    = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_operand_xfer.sv
// Directed bench for ecc_operand_xfer with a behavioural model of the unit's word port,
// operand RAM and scalar register.
module tb_ecc_operand_xfer;

   localparam int RD_OP_LAT  = 16;
   localparam int RD_KEY_LAT = 13;
`ifdef ECC_OPERAND_XFER_READBACK_CHECK_EN
   localparam int WR_OP_LAT  = 14 + RD_OP_LAT;
   localparam int WR_KEY_LAT = 14 + RD_KEY_LAT;
`else
   localparam int WR_OP_LAT  = 14;
   localparam int WR_KEY_LAT = 14;
`endif

   logic         clk;
   logic         reset_n;
   logic         wr_req_i, rd_req_i, sel_i;
   logic [7:0]   addr_i;
   logic [384:0] wdata_i;
   logic [383:0] rdata_o;
   logic         done_o, err_o, mismatch_o, busy_o;
   logic         unit_busy_i;
   logic [7:0]   u_addr_o;
   logic         u_wr_en_o;
   logic [1:0]   u_wr_op_sel_o;
   logic [3:0]   u_wr_word_sel_o;
   logic         u_rd_reg_o;
   logic [1:0]   u_rd_op_sel_o;
   logic [3:0]   u_rd_word_sel_o;
   logic [31:0]  u_wdata_o;
   logic [31:0]  u_rdata_i;

   ecc_operand_xfer dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .wr_req_i        (wr_req_i),
      .rd_req_i        (rd_req_i),
      .sel_i           (sel_i),
      .addr_i          (addr_i),
      .wdata_i         (wdata_i),
      .rdata_o         (rdata_o),
      .done_o          (done_o),
      .err_o           (err_o),
      .mismatch_o      (mismatch_o),
      .busy_o          (busy_o),
      .unit_busy_i     (unit_busy_i),
      .u_addr_o        (u_addr_o),
      .u_wr_en_o       (u_wr_en_o),
      .u_wr_op_sel_o   (u_wr_op_sel_o),
      .u_wr_word_sel_o (u_wr_word_sel_o),
      .u_rd_reg_o      (u_rd_reg_o),
      .u_rd_op_sel_o   (u_rd_op_sel_o),
      .u_rd_word_sel_o (u_rd_word_sel_o),
      .u_wdata_o       (u_wdata_o),
      .u_rdata_i       (u_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- unit model ----------------
   logic [383:0]      ram [256];
   logic [11:0][31:0] stage_q;
   logic [384:0]      key_q;
   logic [383:0]      rdreg_q;
   logic              last_w_q = 1'b0;
   int                commit_cnt = 0;
   logic              corrupt = 1'b0;

   always @(posedge clk) begin
      last_w_q <= u_wr_en_o && (u_wr_op_sel_o == 2'b00) && (u_wr_word_sel_o == 4'hB);
      if (u_wr_en_o) begin
         if (u_wr_op_sel_o == 2'b01) begin
            if (u_wr_word_sel_o == 4'hC)     key_q[384] <= u_wdata_o[0];
            else if (u_wr_word_sel_o < 4'hC) key_q[32*u_wr_word_sel_o +: 32] <= u_wdata_o;
         end else if (u_wr_word_sel_o < 4'hC) begin
            stage_q[u_wr_word_sel_o] <= u_wdata_o;
         end
      end
      if (last_w_q && !u_wr_en_o) begin
         ram[u_addr_o] <= stage_q;
         commit_cnt    <= commit_cnt + 1;
      end
      if (u_rd_reg_o) rdreg_q <= ram[u_addr_o];
   end

   always_comb begin
      u_rdata_i = 32'h0;
      if (u_rd_word_sel_o < 4'hC) begin
         if (u_rd_op_sel_o == 2'b01) u_rdata_i = key_q[32*u_rd_word_sel_o +: 32];
         else                        u_rdata_i = rdreg_q[32*u_rd_word_sel_o +: 32];
      end
      if (corrupt && (u_rd_word_sel_o == 4'h3)) u_rdata_i = u_rdata_i ^ 32'h0000_0100;
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [383:0] last_rd = '0;

   task automatic check(input string name, input logic [399:0] act, input logic [399:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic         wr, rd, sel;
      logic [7:0]   addr;
      logic [384:0] wdata;
      int           exp_done;
      int           exp_words;
      int           exp_rdreg;
      logic [383:0] exp_rdata;
      logic         exp_mm;
   } vec_t;

   function automatic vec_t mkv(input logic wr, input logic rd, input logic sel,
                                input logic [7:0] a, input logic [384:0] d, input int dn,
                                input int words, input int rdreg, input logic [383:0] er,
                                input logic mm);
      vec_t v;
      v.wr = wr; v.rd = rd; v.sel = sel; v.addr = a; v.wdata = d;
      v.exp_done = dn; v.exp_words = words; v.exp_rdreg = rdreg;
      v.exp_rdata = er; v.exp_mm = mm;
      return v;
   endfunction

   function automatic logic [383:0] mk(input logic [31:0] seed);
      logic [383:0] r;
      for (int i = 0; i < 12; i++) r[32*i +: 32] = seed + 32'h0101_0101 * i;
      return r;
   endfunction

   function automatic logic [31:0] exp_word(input logic [384:0] d, input int k);
      if (k == 12) return {31'b0, d[384]};
      if (k > 12)  return 32'hFFFF_FFFF;
      return d[32*k +: 32];
   endfunction

   task automatic issue(input logic wr, input logic rd, input logic sel,
                        input logic [7:0] a, input logic [384:0] d);
      wr_req_i = wr; rd_req_i = rd; sel_i = sel; addr_i = a; wdata_i = d;
      @(negedge clk);
      wr_req_i = 1'b0; rd_req_i = 1'b0; sel_i = ~sel; addr_i = ~a; wdata_i = ~d;
   endtask

   task automatic do_txn(input vec_t v, input string tag);
      int c, k, done_cyc, rdreg_cyc, addr_bad, word_bad;
      logic [7:0]   ea;
      logic [383:0] rd_at_done;
      logic         mm_at_done;
      ea = v.sel ? 8'h00 : v.addr;
      c = 1; k = 0; done_cyc = 0; rdreg_cyc = 0; addr_bad = 0; word_bad = 0;
      rd_at_done = '0; mm_at_done = 1'b0;
      issue(v.wr, v.rd, v.sel, v.addr, v.wdata);
      while (1) begin
         if (u_wr_en_o) begin
            if (u_wr_word_sel_o != 4'(k) || u_wdata_o != exp_word(v.wdata, k) ||
                u_wr_op_sel_o != {1'b0, v.sel}) word_bad++;
            k++;
         end
         if (u_rd_reg_o && rdreg_cyc == 0) rdreg_cyc = c;
         if (u_addr_o != ea || !busy_o) addr_bad++;
         if (done_o) begin
            done_cyc = c; rd_at_done = rdata_o; mm_at_done = mismatch_o;
            break;
         end
         if (c >= 60) break;
         @(negedge clk);
         c++;
      end
      check({tag, "_done_cycle"}, done_cyc, v.exp_done);
      check({tag, "_addr_busy"}, addr_bad, 0);
      check({tag, "_mismatch"}, mm_at_done, v.exp_mm);
      if (v.wr) begin
         check({tag, "_word_count"}, k, v.exp_words);
         check({tag, "_word_data"}, word_bad, 0);
         check({tag, "_rdata_held"}, rd_at_done, last_rd);
      end else begin
         check({tag, "_rd_strobe_cycle"}, rdreg_cyc, v.exp_rdreg);
         check({tag, "_rdata"}, rd_at_done, v.exp_rdata);
         last_rd = v.exp_rdata;
      end
      @(negedge clk);
      check({tag, "_post_done_busy"}, {done_o, busy_o}, 2'b00);
      check({tag, "_post_addr"}, u_addr_o, ea);
      @(negedge clk);
      check({tag, "_addr_release"}, u_addr_o, 8'h00);
   endtask

   vec_t         vecs [7];
   logic [383:0] val_a, val_k, val_c, val_d;
   vec_t         v;
   int           cb, nb, c;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; unit_busy_i = 1'b0;
      wr_req_i = 1'b0; rd_req_i = 1'b0; sel_i = 1'b0; addr_i = '0; wdata_i = '0;
      val_a = {6{64'h0123_4567_89AB_CDEF}};
      val_k = mk(32'hA5C3_0011);
      val_c = mk(32'h1357_9BDF);
      val_d = mk(32'hDEAD_0000);

      vecs[0] = mkv(1, 0, 0, 8'h05, {1'b0, val_a}, WR_OP_LAT,  12, 0, '0,    0);
      vecs[1] = mkv(0, 1, 0, 8'h05, '0,            RD_OP_LAT,  0,  3, val_a, 0);
      vecs[2] = mkv(1, 0, 1, 8'h5A, {1'b1, val_k}, WR_KEY_LAT, 13, 0, '0,    0);
      vecs[3] = mkv(0, 1, 1, 8'h5A, '0,            RD_KEY_LAT, 0,  0, val_k, 0);
      vecs[4] = mkv(1, 1, 0, 8'h33, {1'b0, val_c}, WR_OP_LAT,  12, 0, '0,    0);
      vecs[5] = mkv(0, 1, 0, 8'h33, '0,            RD_OP_LAT,  0,  3, val_c, 0);
      vecs[6] = mkv(0, 1, 0, 8'h05, '0,            RD_OP_LAT,  0,  3, val_a, 0);

      #1;
      check("reset_ctrl", {done_o, err_o, mismatch_o, busy_o, u_wr_en_o, u_rd_reg_o}, 6'b0);
      check("reset_port", {u_addr_o, u_wr_op_sel_o, u_wr_word_sel_o, u_rd_op_sel_o,
                           u_rd_word_sel_o, u_wdata_o}, '0);
      check("reset_rdata", rdata_o, '0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_after_reset", {busy_o, done_o, err_o}, 3'b000);

      for (int i = 0; i < 7; i++) do_txn(vecs[i], $sformatf("vec%0d", i));
      check("key_msb_written", key_q[384], 1'b1);
      check("ram_33_contents", ram[8'h33], val_c);

      // Abort a write at word 6: error pulse, no commit, RAM keeps the old operand.
      cb = commit_cnt;
      issue(1, 0, 0, 8'h05, {1'b0, val_d});
      c = 0;
      while (!(u_wr_en_o && u_wr_word_sel_o == 4'd6) && c < 20) begin
         @(negedge clk);
         c++;
      end
      check("abort_reach_w6", u_wr_word_sel_o, 4'd6);
      unit_busy_i = 1'b1;
      @(negedge clk);
      check("abort_err_pulse", {err_o, done_o, busy_o, u_wr_en_o}, 4'b1000);
      @(negedge clk);
      check("abort_err_one_cycle", err_o, 1'b0);
      unit_busy_i = 1'b0;
      @(negedge clk);
      check("abort_no_commit", commit_cnt, cb);
      do_txn(vecs[1], "abort_readback");

      // A request while the unit is busy is ignored outright.
      unit_busy_i = 1'b1;
      issue(1, 0, 0, 8'h05, {1'b0, val_d});
      nb = 0;
      for (int i = 0; i < 4; i++) begin
         if (busy_o || u_wr_en_o || done_o || err_o) nb++;
         @(negedge clk);
      end
      check("busy_req_ignored", nb, 0);
      unit_busy_i = 1'b0;
      do_txn(vecs[6], "ignored_readback");

`ifdef ECC_OPERAND_XFER_READBACK_CHECK_EN
      corrupt = 1'b1;
      v = mkv(1, 0, 0, 8'h40, {1'b0, val_d}, WR_OP_LAT, 12, 0, '0, 1);
      do_txn(v, "rb_corrupt");
      corrupt = 1'b0;
`endif

      // Reset mid-write drops everything to idle immediately.
      issue(1, 0, 0, 8'h77, {1'b0, val_d});
      repeat (3) @(negedge clk);
      check("rst_pre_busy", busy_o, 1'b1);
      reset_n = 1'b0;
      #1;
      check("rst_mid_ctrl", {busy_o, u_wr_en_o, done_o, err_o, u_rd_reg_o}, 5'b0);
      check("rst_mid_port", {u_wdata_o, u_wr_word_sel_o, u_addr_o}, '0);
      check("rst_mid_rdata", rdata_o, '0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_no_commit_77", {busy_o, last_w_q}, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ecc_operand_xfer.md
Name: ecc_operand_xfer

Overview:
- Host-side master for the ECC arithmetic unit's 32-bit word-mapped register port.
- Write path: takes a full 384-bit operand (or 385-bit scalar) plus RAM address and serialises it into word writes; the write is committed to operand RAM.
- Read path: fetches an operand from RAM, or reads the scalar register, and reassembles the 384-bit value.
- Sits between the command sequencer/AHB shim and the arithmetic unit; only one transfer is in flight at a time.

Parameters:
- REG_SIZE, 384, operand width in bits.
- WORD_W, 32, port word width.
- RD_LAT, 2, cycles from addr_o valid to RAM data valid for read capture (1 cycle address register + 1 cycle RAM).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- wr_req_i  in  1  start write transfer (sampled in IDLE)
- rd_req_i  in  1  start read transfer (sampled in IDLE)
- sel_i  in  1  0 = operand RAM, 1 = secret scalar
- addr_i  in  8  operand RAM address (ignored when sel_i=1)
- wdata_i  in  REG_SIZE+1  write value; bit REG_SIZE used only for the scalar
- rdata_o  out  REG_SIZE  assembled read value, held until the next read completes
- done_o  out  1  one-cycle pulse at transfer completion
- err_o  out  1  one-cycle pulse on abort
- mismatch_o  out  1  readback-compare failure, see Optional Feature
- busy_o  out  1  transfer in progress
- unit_busy_i  in  1  arithmetic unit running a point operation
- u_addr_o  out  8  unit address
- u_wr_en_o  out  1  unit word write strobe
- u_wr_op_sel_o  out  2  unit write target
- u_wr_word_sel_o  out  4  unit write word index
- u_rd_reg_o  out  1  unit read-capture strobe
- u_rd_op_sel_o  out  2  unit read source
- u_rd_word_sel_o  out  4  unit read word index
- u_wdata_o  out  32  unit write data
- u_rdata_i  in  32  unit read data (combinational in u_rd_word_sel_o)

Behaviour:
- Reset values: all outputs 0; state IDLE; rdata_o = 0.
- Request acceptance:
  - Requests are accepted only in IDLE with unit_busy_i=0; otherwise they are ignored and no pulse is produced.
  - wr_req_i and rd_req_i asserted together: write wins.
  - The request is single-cycle sampled; all request inputs are latched on acceptance.
- u_addr_o is driven from the latched address for the whole transfer and for one cycle after it.
- States: IDLE, WR_WORD, WR_COMMIT, RD_WAIT, RD_CAP, RD_WORD, DONE.
- WR_WORD:
  - One word per cycle, index k = 0..11; u_wr_en_o=1, u_wr_word_sel_o=k, u_wdata_o=wdata[32k+31:32k], u_wr_op_sel_o = {1'b0, sel}.
  - For the scalar, a 13th word k=0xC carries {31'b0, wdata[384]}.
- WR_COMMIT (operand only): one cycle with u_wr_en_o=0 and address held; the unit's RAM write strobe fires here. The scalar skips this state.
- Write latency, accept to done_o: operand 14 cycles (12 words + commit + DONE); scalar 14 cycles (13 words + DONE).
- Operand read:
  - RD_WAIT holds for RD_LAT cycles.
  - RD_CAP pulses u_rd_reg_o for 1 cycle.
  - RD_WORD steps k = 0..11 with u_rd_op_sel_o=0, u_rd_word_sel_o=k, sampling u_rdata_i into a shadow register at [32k+31:32k] in the same cycle.
- Scalar read: goes straight to RD_WORD with u_rd_op_sel_o=1; no capture strobe.
- rdata_o updates from the shadow register only in DONE, so a partial value is never visible.
- Read latency: operand RD_LAT+14 cycles; scalar 13 cycles.
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o=1 in every non-IDLE state.
- unit_busy_i rising in any non-IDLE state:
  - Abort to IDLE the next cycle: err_o pulse, no done_o, rdata_o unchanged.
  - An aborted operand write never reaches WR_COMMIT, so RAM is not written.
- Word counter: 4-bit, saturates at the final index and never wraps.
- Reset mid-transfer: immediate return to IDLE with all strobes 0.

Optional Feature:
- Macro: ECC_OPERAND_XFER_READBACK_CHECK_EN.
- Defined:
  - After DONE of any write, an automatic read of the same target runs without pulsing done_o.
  - The final done_o fires after the readback.
  - mismatch_o pulses together with that done_o if the readback differs from wdata_i; rdata_o is not updated by the check.
  - Write latency becomes write + read latency.
- Undefined: mismatch_o is tied to 0 and no extra states exist.

Decomposition:
- ecc_xfer_pkg:
  - State enum.
  - NUM_WORDS=12, SCALAR_WORDS=13, WORD_W=32.
  - Target encodings OP_SEL_REG=2'b00, OP_SEL_KEY=2'b01.
  - LAST_WORD=4'hB, KEY_MSB_WORD=4'hC.
- One natural sub-module, ecc_xfer_rd_assembler: word-indexed shadow register with a load-to-output strobe.

Test Plan:
- Operand write 384'h0123…CDEF to address 0x05 -> words 0..B in consecutive cycles, commit cycle with u_addr_o=0x05, done_o at cycle 14.
- Scalar write with bit384=1 -> 13 words, word 0xC data = 32'h1, no commit cycle, done_o at cycle 14.
- Operand read of address 0x05 after the write, RD_LAT=2 -> u_rd_reg_o at cycle 3, rdata_o equals the written value at done_o (cycle 16).
- unit_busy_i asserted at word 6 of a write -> err_o pulse, no commit, subsequent read returns the old RAM contents.
- wr_req_i and rd_req_i in the same cycle while unit_busy_i=0 -> write performed; request with unit_busy_i=1 -> busy_o stays 0.
- ECC_OPERAND_XFER_READBACK_CHECK_EN with the bench corrupting u_rdata_i word 3 -> mismatch_o=1 with the single done_o.
